// File: rtl/expipe_pkg.sv
// Execution-pipeline shared types: ROB index, exception cause and commit FSM states.
package expipe_pkg;
  localparam int unsigned ROB_DEPTH       = 8;
  localparam int unsigned ROB_IDX_LEN     = $clog2(ROB_DEPTH);
  localparam int unsigned EXCEPT_CODE_LEN = 4;

  typedef logic [ROB_IDX_LEN-1:0]     rob_idx_t;
  typedef logic [EXCEPT_CODE_LEN-1:0] except_code_t;

  localparam except_code_t E_INSTR_ADDR_MISALIGNED = 4'h0;
  localparam except_code_t E_INSTR_ACCESS_FAULT    = 4'h1;
  localparam except_code_t E_ILLEGAL_INSTRUCTION   = 4'h2;
  localparam except_code_t E_BREAKPOINT            = 4'h3;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_EXCEPT = 2'd1,
    S_FLUSH  = 2'd2
  } commit_state_t;
endpackage

// File: rtl/len5_pkg.sv
// Global LEN5 core parameters shared by every pipeline stage.
package len5_pkg;
  localparam int unsigned XLEN = 64;
endpackage

// File: rtl/int_commit_unit_instret.sv
// 64-bit retired-instruction counter, enable-only, wraps to zero.
// Exists only when LEN5_COMMIT_INSTRET_EN is defined.
`ifdef LEN5_COMMIT_INSTRET_EN
module int_commit_unit_instret (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [63:0] cnt_o
);
  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  always_comb begin
    if (en_i) begin
      cnt_d = cnt_q + 64'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule
`endif

// File: rtl/int_commit_unit.sv
// In-order integer commit stage: RF write + status-table notification, exception hand-off and flush.
// Optional retired-instruction counter enabled by LEN5_COMMIT_INSTRET_EN.
module int_commit_unit
  import expipe_pkg::*;
#(
  parameter  int unsigned REG_NUM   = 32,
  parameter  int unsigned XLEN      = len5_pkg::XLEN,
  localparam int unsigned RegIdxLen = $clog2(REG_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rob_head_valid_i,
  output logic                 rob_head_ready_o,
  input  rob_idx_t             rob_head_rob_idx_i,
  input  logic                 rob_head_rd_upd_i,
  input  logic [RegIdxLen-1:0] rob_head_rd_idx_i,
  input  logic [XLEN-1:0]      rob_head_value_i,
  input  logic                 rob_head_except_i,
  input  except_code_t         rob_head_except_code_i,
  input  logic [XLEN-1:0]      rob_head_pc_i,
  output logic                 rf_wr_en_o,
  output logic [RegIdxLen-1:0] rf_wr_idx_o,
  output logic [XLEN-1:0]      rf_wr_data_o,
  output logic                 comm_valid_o,
  output logic [RegIdxLen-1:0] comm_rd_idx_o,
  output logic                 except_valid_o,
  input  logic                 except_ready_i,
  output except_code_t         except_code_o,
  output logic [XLEN-1:0]      except_pc_o,
  output logic                 flush_o
`ifdef LEN5_COMMIT_INSTRET_EN
  ,
  output logic [63:0]          instret_o
`endif
);
  function automatic logic writes_rf(input logic rd_upd, input logic [RegIdxLen-1:0] rd_idx);
    return rd_upd && (rd_idx != {RegIdxLen{1'b0}});
  endfunction

  commit_state_t          state_q;
  logic                   rf_wr_en_q;
  logic [RegIdxLen-1:0]   rf_wr_idx_q;
  logic [XLEN-1:0]        rf_wr_data_q;
  logic                   comm_valid_q;
  logic [RegIdxLen-1:0]   comm_rd_idx_q;
  logic                   except_valid_q;
  except_code_t           except_code_q;
  logic [XLEN-1:0]        except_pc_q;
  logic                   flush_q;

  logic                   head_fire_s;
  logic                   head_wr_s;
  logic                   unused_rob_idx_s;

  // The ROB index is carried for tracing only; commit order is implied by the head.
  assign unused_rob_idx_s = ^rob_head_rob_idx_i;

  assign head_fire_s = rob_head_valid_i && (state_q == S_RUN);
  assign head_wr_s   = writes_rf(rob_head_rd_upd_i, rob_head_rd_idx_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_RUN;
      rf_wr_en_q     <= 1'b0;
      rf_wr_idx_q    <= {RegIdxLen{1'b0}};
      rf_wr_data_q   <= {XLEN{1'b0}};
      comm_valid_q   <= 1'b0;
      comm_rd_idx_q  <= {RegIdxLen{1'b0}};
      except_valid_q <= 1'b0;
      except_code_q  <= {EXCEPT_CODE_LEN{1'b0}};
      except_pc_q    <= {XLEN{1'b0}};
      flush_q        <= 1'b0;
    end else begin
      // Write and notification strobes are single-cycle pulses.
      rf_wr_en_q   <= 1'b0;
      comm_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (head_fire_s) begin
            if (rob_head_except_i) begin
              except_valid_q <= 1'b1;
              except_code_q  <= rob_head_except_code_i;
              except_pc_q    <= rob_head_pc_i;
              state_q        <= S_EXCEPT;
            end else begin
              rf_wr_en_q    <= head_wr_s;
              comm_valid_q  <= head_wr_s;
              rf_wr_idx_q   <= rob_head_rd_idx_i;
              rf_wr_data_q  <= rob_head_value_i;
              comm_rd_idx_q <= rob_head_rd_idx_i;
            end
          end
        end
        S_EXCEPT: begin
          if (except_ready_i) begin
            except_valid_q <= 1'b0;
            flush_q        <= 1'b1;
            state_q        <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          state_q <= S_RUN;
        end
        default: begin
          except_valid_q <= 1'b0;
          state_q        <= S_RUN;
        end
      endcase
    end
  end

  assign rob_head_ready_o = (state_q == S_RUN);
  assign rf_wr_en_o       = rf_wr_en_q;
  assign rf_wr_idx_o      = rf_wr_idx_q;
  assign rf_wr_data_o     = rf_wr_data_q;
  assign comm_valid_o     = comm_valid_q;
  assign comm_rd_idx_o    = comm_rd_idx_q;
  assign except_valid_o   = except_valid_q;
  assign except_code_o    = except_code_q;
  assign except_pc_o      = except_pc_q;
  assign flush_o          = flush_q;

`ifdef LEN5_COMMIT_INSTRET_EN
  int_commit_unit_instret commit_instret_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (head_fire_s && !rob_head_except_i),
    .cnt_o (instret_o)
  );
`endif
endmodule

// File: tb/tb_int_commit_unit.sv
// Directed self-checking bench for int_commit_unit (instret checks active with LEN5_COMMIT_INSTRET_EN).
module tb_int_commit_unit;
  import expipe_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              head_valid;
  logic              head_ready;
  rob_idx_t          head_rob_idx;
  logic              head_rd_upd;
  logic [4:0]        head_rd_idx;
  logic [63:0]       head_value;
  logic              head_except;
  except_code_t      head_code;
  logic [63:0]       head_pc;
  logic              rf_wr_en;
  logic [4:0]        rf_wr_idx;
  logic [63:0]       rf_wr_data;
  logic              comm_valid;
  logic [4:0]        comm_rd_idx;
  logic              except_valid;
  logic              except_ready;
  except_code_t      except_code;
  logic [63:0]       except_pc;
  logic              flush;
`ifdef LEN5_COMMIT_INSTRET_EN
  logic [63:0]       instret;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_instret = 64'd0;

  always #5 clk = ~clk;

  int_commit_unit dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .rob_head_valid_i       (head_valid),
    .rob_head_ready_o       (head_ready),
    .rob_head_rob_idx_i     (head_rob_idx),
    .rob_head_rd_upd_i      (head_rd_upd),
    .rob_head_rd_idx_i      (head_rd_idx),
    .rob_head_value_i       (head_value),
    .rob_head_except_i      (head_except),
    .rob_head_except_code_i (head_code),
    .rob_head_pc_i          (head_pc),
    .rf_wr_en_o             (rf_wr_en),
    .rf_wr_idx_o            (rf_wr_idx),
    .rf_wr_data_o           (rf_wr_data),
    .comm_valid_o           (comm_valid),
    .comm_rd_idx_o          (comm_rd_idx),
    .except_valid_o         (except_valid),
    .except_ready_i         (except_ready),
    .except_code_o          (except_code),
    .except_pc_o            (except_pc),
    .flush_o                (flush)
`ifdef LEN5_COMMIT_INSTRET_EN
    ,
    .instret_o              (instret)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    head_valid   = 1'b0;
    head_rob_idx = 3'd0;
    head_rd_upd  = 1'b0;
    head_rd_idx  = 5'd0;
    head_value   = 64'd0;
    head_except  = 1'b0;
    head_code    = 4'h0;
    head_pc      = 64'd0;
    except_ready = 1'b0;
  endtask

  task automatic drive_normal(input logic [4:0] rd, input logic upd, input logic [63:0] val);
    head_valid   = 1'b1;
    head_rob_idx = head_rob_idx + 3'd1;
    head_rd_upd  = upd;
    head_rd_idx  = rd;
    head_value   = val;
    head_except  = 1'b0;
  endtask

  task automatic drive_except(input except_code_t code, input logic [63:0] pc);
    head_valid  = 1'b1;
    head_rd_upd = 1'b1;
    head_rd_idx = 5'd9;
    head_value  = 64'hDEAD;
    head_except = 1'b1;
    head_code   = code;
    head_pc     = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    checks++;
    if ({rf_wr_en, comm_valid, except_valid, flush, head_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00001", {rf_wr_en, comm_valid, except_valid, flush, head_ready});
    end
    checks++;
    if ({rf_wr_idx, rf_wr_data, comm_rd_idx, except_code, except_pc} !== 142'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {rf_wr_idx, rf_wr_data, comm_rd_idx, except_code, except_pc});
    end
`ifdef LEN5_COMMIT_INSTRET_EN
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("FAIL reset_instret: got %h expected 0", instret);
    end
`endif
    step();
    step();
    rst = 1'b0;
    exp_instret = 64'd0;
  endtask

  task automatic test_back_to_back();
    drive_normal(5'd5, 1'b1, 64'hA);
    checks++;
    if (head_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b expected 1", head_ready);
    end
    step();
    exp_instret++;
    drive_normal(5'd7, 1'b1, 64'hB);
    checks++;
    if ({rf_wr_en, rf_wr_idx, rf_wr_data, comm_valid, comm_rd_idx} !== {1'b1, 5'd5, 64'hA, 1'b1, 5'd5}) begin
      errors++;
      $display("FAIL b2b_first: got en=%b idx=%0d data=%h cv=%b cidx=%0d expected 1/5/a/1/5",
               rf_wr_en, rf_wr_idx, rf_wr_data, comm_valid, comm_rd_idx);
    end
    step();
    exp_instret++;
    head_valid = 1'b0;
    checks++;
    if ({rf_wr_en, rf_wr_idx, rf_wr_data, comm_valid, comm_rd_idx} !== {1'b1, 5'd7, 64'hB, 1'b1, 5'd7}) begin
      errors++;
      $display("FAIL b2b_second: got en=%b idx=%0d data=%h cv=%b cidx=%0d expected 1/7/b/1/7",
               rf_wr_en, rf_wr_idx, rf_wr_data, comm_valid, comm_rd_idx);
    end
`ifdef LEN5_COMMIT_INSTRET_EN
    checks++;
    if (instret !== 64'd2) begin
      errors++;
      $display("FAIL b2b_instret: got %0d expected 2", instret);
    end
`endif
    step();
    checks++;
    if ({rf_wr_en, comm_valid} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_pulse_width: got %b expected 00", {rf_wr_en, comm_valid});
    end
  endtask

  task automatic test_no_write();
    drive_normal(5'd0, 1'b1, 64'h1234);
    step();
    exp_instret++;
    drive_normal(5'd3, 1'b0, 64'h5678);
    checks++;
    if ({rf_wr_en, comm_valid} !== 2'b00) begin
      errors++;
      $display("FAIL x0_write: got %b expected 00", {rf_wr_en, comm_valid});
    end
    step();
    exp_instret++;
    head_valid = 1'b0;
    checks++;
    if ({rf_wr_en, comm_valid} !== 2'b00) begin
      errors++;
      $display("FAIL no_upd_write: got %b expected 00", {rf_wr_en, comm_valid});
    end
`ifdef LEN5_COMMIT_INSTRET_EN
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL no_write_instret: got %0d expected %0d", instret, exp_instret);
    end
`endif
    step();
  endtask

  task automatic test_exception_wait();
    except_ready = 1'b0;
    drive_except(E_ILLEGAL_INSTRUCTION, 64'h100);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({except_valid, except_code, except_pc, head_ready, flush, rf_wr_en, comm_valid} !==
          {1'b1, 4'h2, 64'h100, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL exc_hold[%0d]: got ev=%b code=%h pc=%h rdy=%b fl=%b wr=%b cv=%b expected 1/2/100/0/0/0/0",
                 i, except_valid, except_code, except_pc, head_ready, flush, rf_wr_en, comm_valid);
      end
      if (i == 3) except_ready = 1'b1;
      step();
    end
    except_ready = 1'b0;
    checks++;
    if ({flush, except_valid, head_ready} !== 3'b100) begin
      errors++;
      $display("FAIL exc_flush: got fl/ev/rdy=%b expected 100", {flush, except_valid, head_ready});
    end
    step();
    checks++;
    if ({flush, except_valid, head_ready} !== 3'b001) begin
      errors++;
      $display("FAIL exc_return: got fl/ev/rdy=%b expected 001", {flush, except_valid, head_ready});
    end
`ifdef LEN5_COMMIT_INSTRET_EN
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL exc_instret: got %0d expected %0d", instret, exp_instret);
    end
`endif
  endtask

  task automatic test_exception_fast();
    except_ready = 1'b1;
    drive_except(E_BREAKPOINT, 64'h2000);
    step();
    drive_normal(5'd12, 1'b1, 64'h55);
    checks++;
    if ({except_valid, except_code, except_pc, head_ready, flush} !== {1'b1, 4'h3, 64'h2000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fast_t1: got ev=%b code=%h pc=%h rdy=%b fl=%b expected 1/3/2000/0/0",
               except_valid, except_code, except_pc, head_ready, flush);
    end
    step();
    checks++;
    if ({flush, except_valid, head_ready, rf_wr_en} !== 4'b1000) begin
      errors++;
      $display("FAIL fast_t2: got fl/ev/rdy/wr=%b expected 1000", {flush, except_valid, head_ready, rf_wr_en});
    end
    step();
    checks++;
    if ({flush, except_valid, head_ready, rf_wr_en} !== 4'b0010) begin
      errors++;
      $display("FAIL fast_t3: got fl/ev/rdy/wr=%b expected 0010", {flush, except_valid, head_ready, rf_wr_en});
    end
    step();
    exp_instret++;
    head_valid   = 1'b0;
    except_ready = 1'b0;
    checks++;
    if ({rf_wr_en, rf_wr_idx, rf_wr_data, comm_valid} !== {1'b1, 5'd12, 64'h55, 1'b1}) begin
      errors++;
      $display("FAIL fast_consume: got en=%b idx=%0d data=%h cv=%b expected 1/12/55/1",
               rf_wr_en, rf_wr_idx, rf_wr_data, comm_valid);
    end
    step();
  endtask

  task automatic test_reset_mid_except();
    except_ready = 1'b0;
    drive_except(E_INSTR_ACCESS_FAULT, 64'h300);
    step();
    idle_inputs();
    checks++;
    if (except_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got ev=%b expected 1", except_valid);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({rf_wr_en, comm_valid, except_valid, flush, head_ready, except_code, except_pc} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 64'h0}) begin
      errors++;
      $display("FAIL rst_mid_async: got wr/cv/ev/fl/rdy=%b code=%h pc=%h expected 00001/0/0",
               {rf_wr_en, comm_valid, except_valid, flush, head_ready}, except_code, except_pc);
    end
    rst = 1'b0;
    exp_instret = 64'd0;
    except_ready = 1'b1;
    step();
    checks++;
    if ({flush, except_valid, head_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rst_mid_after: got fl/ev/rdy=%b expected 001", {flush, except_valid, head_ready});
    end
    step();
    except_ready = 1'b0;
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_noflush: got %b expected 0", flush);
    end
`ifdef LEN5_COMMIT_INSTRET_EN
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid_instret: got %0d expected 0", instret);
    end
`endif
  endtask

`ifdef LEN5_COMMIT_INSTRET_EN
  task automatic test_instret_wrap();
    force dut.commit_instret_cnt.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.commit_instret_cnt.cnt_q;
    checks++;
    if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h expected ffffffffffffffff", instret);
    end
    drive_normal(5'd4, 1'b1, 64'h77);
    step();
    head_valid = 1'b0;
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("FAIL wrap_instret: got %h expected 0", instret);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_no_write();
    test_exception_wait();
    test_exception_fast();
    test_reset_mid_except();
`ifdef LEN5_COMMIT_INSTRET_EN
    test_instret_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
